// File: rtl/io_irq_ctrl.sv
// Interrupt controller for IO bank 0x0007: synchronized sources, mask/pending/vector
// registers and a registered IRQ to the 65C02. Define IO_IRQ_EDGE_EN to build edge sources.
module io_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               R_W_n,
    input  logic [2:0]         reg_addr_i,
    input  logic [2:0]         reg_addr_r_i,
    input  logic [7:0]         data_i,
    input  logic               irqc_cs,
    output logic [7:0]         data_o,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o
);

    localparam logic [7:0] IMPL = 8'((9'd1 << NUM_SRC) - 9'd1);

    logic [7:0] src_ext;
    logic [7:0] sync_a;
    logic [7:0] sync_b;
    logic [7:0] mask;
    logic [7:0] edge_sel;
    logic [7:0] pending;
    logic [7:0] masked;
    logic [7:0] rd_next;
    logic [2:0] idx;
    logic       gie;
    logic       we;
    logic       active;

    always_comb begin
        src_ext = '0;
        for (int i = 0; i < NUM_SRC; i++) src_ext[i] = src_i[i];
    end

    assign we = irqc_cs & ~R_W_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= src_ext;
            sync_b <= sync_a;
        end
    end

`ifdef IO_IRQ_EDGE_EN
    logic [7:0] s_prev;
    logic [7:0] lat;
    logic [7:0] lat_next;
    logic [7:0] sw_set;
    logic [7:0] w1c;

    // The latch is held at 0 while a bit is level, so a 0->1 EDGE switch starts clean.
    always_comb begin
        sw_set   = (we && reg_addr_i == 3'd6) ? data_i : 8'h00;
        w1c      = (we && reg_addr_i == 3'd1) ? data_i : 8'h00;
        lat_next = edge_sel & ((sync_b & ~s_prev) | sw_set | (lat & ~w1c));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_prev   <= '0;
            lat      <= '0;
            edge_sel <= '0;
        end else begin
            s_prev <= sync_b;
            lat    <= lat_next & IMPL;
            if (we && reg_addr_i == 3'd3) edge_sel <= data_i & IMPL;
        end
    end

    assign pending = (edge_sel & lat) | (~edge_sel & sync_b);
`else
    assign edge_sel = 8'h00;
    assign pending  = sync_b;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask <= '0;
            gie  <= 1'b0;
        end else if (we) begin
            if (reg_addr_i == 3'd2) mask <= data_i & IMPL;
            if (reg_addr_i == 3'd5) gie  <= data_i[0];
        end
    end

    assign masked = pending & mask;
    assign active = |masked;

    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) idx = i[2:0];
        end
    end

    always_comb begin
        rd_next = 8'h00;
        case (reg_addr_r_i)
            3'd0:    rd_next = masked;
            3'd1:    rd_next = pending;
            3'd2:    rd_next = mask;
            3'd3:    rd_next = edge_sel;
            3'd4:    rd_next = {active, 4'b0000, idx};
            3'd5:    rd_next = {7'b0000000, gie};
            default: rd_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= 8'h00;
            irq_o  <= 1'b0;
        end else begin
            data_o <= rd_next;
            irq_o  <= gie & active;
        end
    end

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Self-checking bench for io_irq_ctrl: directed scenarios plus random bus/source traffic
// compared every cycle against a register-level reference model.
module tb_io_irq_ctrl;

`ifdef IO_IRQ_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_w_n = 1'b1;
    logic [2:0] reg_addr = 3'd0;
    logic [2:0] reg_addr_r = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic       cs = 1'b0;
    logic [7:0] data_out;
    logic [7:0] src = 8'h00;
    logic       irq;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [7:0] m_mask, m_edge, m_lat;
    logic       m_gie;
    logic [7:0] src_q[$];      // src_q[0] = sample at last edge; s = src_q[1]
    logic [7:0] exp_rd;
    logic       exp_irq;

    io_irq_ctrl #(.NUM_SRC(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .R_W_n       (r_w_n),
        .reg_addr_i  (reg_addr),
        .reg_addr_r_i(reg_addr_r),
        .data_i      (data_in),
        .irqc_cs     (cs),
        .data_o      (data_out),
        .src_i       (src),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mask = 8'h00; m_edge = 8'h00; m_lat = 8'h00; m_gie = 1'b0;
        src_q = {8'h00, 8'h00, 8'h00};
    endtask

    function automatic logic [7:0] m_pending();
        return (m_edge & m_lat) | (~m_edge & src_q[1]);
    endfunction

    function automatic logic [7:0] m_vector();
        logic [7:0] p;
        p = m_pending() & m_mask;
        for (int n = 0; n < 8; n++)
            if (p[n]) return 8'h80 + 8'(n);
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_pending() & m_mask;
            3'd1:    return m_pending();
            3'd2:    return m_mask;
            3'd3:    return m_edge;
            3'd4:    return m_vector();
            3'd5:    return {7'd0, m_gie};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, advance the model, check after the edge.
    task automatic tick();
        logic       we;
        logic [7:0] wdata, rise, set_m, clr_m, newe;
        exp_rd  = m_read(reg_addr_r);
        exp_irq = m_gie && (m_vector() != 8'h00);
        we    = cs & ~r_w_n;
        wdata = data_in;
        rise  = src_q[1] & ~src_q[2];
        set_m = m_edge & (rise | ((we && reg_addr == 3'd6) ? wdata : 8'h00));
        clr_m = m_edge & ((we && reg_addr == 3'd1) ? wdata : 8'h00);
        m_lat = (m_lat & ~clr_m) | set_m;
        if (we && reg_addr == 3'd2) m_mask = wdata;
        if (we && reg_addr == 3'd5) m_gie = wdata[0];
        if (we && reg_addr == 3'd3 && EDGE_EN) begin
            newe  = wdata;
            m_lat = m_lat & ~(newe & ~m_edge);
            m_edge = newe;
        end
        src_q.push_front(src);
        void'(src_q.pop_back());
        @(posedge clk);
        #1;
        check8("data_o", data_out, exp_rd);
        check1("irq_o", irq, exp_irq);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; r_w_n = 1'b0; reg_addr = a; data_in = d;
        tick();
        cs = 1'b0; r_w_n = 1'b1;
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [7:0] exp, input string tag);
        reg_addr_r = a;
        tick();
        check8(tag, data_out, exp);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        check1("rst_irq", irq, 1'b0);
        check8("rst_data", data_out, 8'h00);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b0;
        @(posedge clk); #1;

        // reset values of every register
        for (int a = 0; a < 8; a++) rd_chk(3'(a), 8'h00, "reset_reg");

        // level source 2
        wr(3'd2, 8'h04);
        wr(3'd5, 8'h01);
        src = 8'h04;
        tick(); tick();
        check1("level_irq_early", irq, 1'b0);
        tick();
        check1("level_irq_set", irq, 1'b1);
        rd_chk(3'd4, 8'h82, "level_vector");
        src = 8'h00;
        tick(); tick();
        check1("level_irq_hold", irq, 1'b1);
        tick();
        check1("level_irq_drop", irq, 1'b0);

        // priority between sources 3 and 6
        src = 8'h48;
        wr(3'd2, 8'h48);
        tick(); tick();
        rd_chk(3'd4, 8'h83, "prio_3");
        rd_chk(3'd1, 8'h48, "prio_pending");
        wr(3'd2, 8'h40);
        rd_chk(3'd4, 8'h86, "prio_6");
        wr(3'd2, 8'h00);
        rd_chk(3'd4, 8'h00, "prio_none");
        tick();
        check1("prio_irq_off", irq, 1'b0);

        // EDGE / SWSET writes
        wr(3'd3, 8'hFF);
        wr(3'd6, 8'hFF);
        rd_chk(3'd3, EDGE_EN ? 8'hFF : 8'h00, "edge_reg");
        rd_chk(3'd1, EDGE_EN ? 8'hFF : 8'h48, "swset_pending");
        wr(3'd1, 8'hFF);
        rd_chk(3'd1, EDGE_EN ? 8'h00 : 8'h48, "w1c_pending");
        wr(3'd3, 8'h00);
        src = 8'h00;
        tick(); tick(); tick();

`ifdef IO_IRQ_EDGE_EN
        // edge latch on source 0
        wr(3'd3, 8'h03);
        wr(3'd2, 8'h01);
        src = 8'h01; tick(); tick();
        src = 8'h00; tick(); tick(); tick();
        rd_chk(3'd1, 8'h01, "edge_latched");
        check1("edge_irq_held", irq, 1'b1);
        wr(3'd1, 8'h01);
        check1("edge_irq_w", irq, 1'b1);
        tick();
        check1("edge_irq_cleared", irq, 1'b0);
        // rising edge of source 1 collides with W1C of bit 1
        src = 8'h02; tick(); tick();
        wr(3'd1, 8'h02);
        rd_chk(3'd1, 8'h02, "collision");
        src = 8'h00;
        wr(3'd3, 8'h00);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cs         = ($urandom_range(0, 2) != 0);
            r_w_n      = ($urandom_range(0, 1) != 0);
            reg_addr   = 3'($urandom_range(0, 7));
            data_in    = 8'($urandom);
            reg_addr_r = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) src = src ^ (8'h01 << $urandom_range(0, 7));
            tick();
            if (i % 97 == 50) reset_pulse();
        end

        // reset in the middle of an active interrupt
        cs = 1'b0; r_w_n = 1'b1;
        src = 8'h10;
        wr(3'd2, 8'h10);
        wr(3'd5, 8'h01);
        tick(); tick(); tick();
        check1("pre_rst_irq", irq, 1'b1);
        reset_pulse();
        rd_chk(3'd2, 8'h00, "post_rst_mask");
        rd_chk(3'd4, 8'h00, "post_rst_vector");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_irq_ctrl.md
# io_irq_ctrl

Interrupt controller on IO bank 0x0007 of the nano6502 CPU bus. It gathers up to eight peripheral interrupt sources (UART, timer, SD, USB, video and others) and drives the 65C02 IRQ input. Mask, pending, edge-select and vector registers are exposed in the 0xFE00–0xFEFF IO page, using the same registered-write / registered-read bus timing as every other peripheral.

## Interface
- `NUM_SRC`, 8: number of implemented sources, 1..8. Unimplemented bits read 0 and are ignored.
- `clk_i` in 1: system clock, same as the CPU clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `R_W_n` in 1: registered bus direction, 0 = write. One cycle behind the CPU address.
- `reg_addr_i` in 3: registered write address (`cpu_addr_w[2:0]`).
- `reg_addr_r_i` in 3: live read address (`cpu_addr[2:0]`).
- `data_i` in 8: CPU write data.
- `irqc_cs` in 1: bank select from the address decoder.
- `data_o` out 8: read data.
- `src_i` in `NUM_SRC`: asynchronous interrupt requests, active-high.
- `irq_o` out 1: interrupt request to the CPU, active-high, registered.

## Operation
- Register map by address:
  - 0 STATUS (RO): `pending & mask`.
  - 1 PENDING (R / W1C): write 1 to clear.
  - 2 MASK (RW).
  - 3 EDGE (RW): 1 = edge-sensitive, 0 = level.
  - 4 VECTOR (RO): `{active, 4'b0, idx[2:0]}`.
  - 5 CTRL (RW): bit0 = GIE, other bits read 0.
  - 6 SWSET (WO): write 1 to set pending on edge sources.
  - 7: reads 0x00.
- Source input: every `src_i` bit passes through a 2-flop synchronizer, giving `s`.
- Level source (EDGE bit = 0): `pending[n] = s[n]` live. W1C and SWSET have no effect.
- Edge source (EDGE bit = 1):
  - The rising edge of `s[n]` (s = 1 and previous s = 0) sets `pending[n]`.
  - PENDING W1C clears it. SWSET sets it.
  - Set and clear in the same cycle: set wins.
- EDGE change: switching a bit 0→1 clears that latched pending bit. Switching 1→0 drops the latch; the bit then follows `s`.
- Priority: lowest index wins.
  - `idx` = lowest n with `pending[n] & mask[n]`.
  - `active` = any such bit. When `active` = 0, `idx` = 0.
- `irq_o` is registered: next value = GIE & `active`.
- Reads have no side effects. Acknowledge is an explicit PENDING W1C.
- Write strobe: `irqc_cs & ~R_W_n` at a `clk_i` rising edge, decoded on `reg_addr_i`.
- Read: `data_o` is registered from `reg_addr_r_i` on every edge, independent of `irqc_cs`. The top-level mux qualifies it.
- Reset values:
  - MASK = 0x00, EDGE = 0x00, GIE = 0, latched pending = 0x00.
  - Synchronizers and edge-history flops = 0.
  - `irq_o` = 0, `data_o` = 0x00.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). Pending edges are lost.

## Timing
- Source latency, with `src_i` rising before edge E0:
  - `s` = 1 after E1.
  - Edge pending set at E2. Level pending is visible combinationally after E1.
  - `irq_o` = 1 after E3 (edge) or E2 (level).
- Write latency: a register written at edge W takes effect after W. A MASK/GIE/W1C change is reflected on `irq_o` after W+1.
- Read latency: `data_o` is valid one cycle after `reg_addr_r_i` is presented, matching RAM/ROM. A read in the cycle right after a write returns the new value.
- Deassertion: clearing the last active pending bit at W drops `irq_o` after W+1, before the CPU's RTI fetch.
- No combinational path from `src_i` or bus inputs to `irq_o`.

## Configuration
- `IO_IRQ_EDGE_EN` defined: EDGE register, edge detection, latched pending and SWSET are built as described above.
- `IO_IRQ_EDGE_EN` undefined: all sources are level-only.
  - EDGE reads 0x00 and writes are ignored.
  - SWSET and PENDING W1C are no-ops.
  - Edge-history flops and the pending latch are not synthesized.

## Test plan
- Reset: assert `rst_i` mid-transfer. Expect `irq_o` = 0 immediately, all registers read 0x00, and VECTOR = 0x00.
- Level: MASK = 0x04, GIE = 1, `src_i[2]` high. Expect `irq_o` = 1 three edges later and VECTOR = 0x82. Drop `src_i[2]`: `irq_o` = 0 three edges later.
- Edge latch: EDGE = 0x01, MASK = 0x01, GIE = 1, pulse `src_i[0]` for 2 cycles. Expect PENDING = 0x01 and `irq_o` held. Write PENDING = 0x01: `irq_o` = 0 at W+1.
- Priority: sources 3 and 6 pending and masked in. Expect VECTOR = 0x83. Clear/mask 3: VECTOR = 0x86. Clear MASK: VECTOR = 0x00.
- Collision: edge on source 1 in the same cycle as W1C of bit 1. Expect PENDING bit 1 = 1.
- Build without `IO_IRQ_EDGE_EN`: write EDGE = 0xFF and SWSET = 0xFF. Expect EDGE reads 0x00 and PENDING tracks `src_i` only.
